// File: rtl/scic_mem_bus.sv
// CPU-facing memory/IO slave: word RAM, LED register, debounced switches and
// sticky switch-press events, all read back through one registered data port.
module scic_mem_bus #(
   parameter int RAM_AW       = 10,
   parameter int DEBOUNCE_CYC = 16,
   parameter int CNT_W        = 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [31:0] data_fromCPU,
   input  logic        we,
   input  logic [3:0]  switches,
   output logic [31:0] data_toCPU,
   output logic [3:0]  LEDs
);

   localparam logic [15:0]      ADDR_LED = 16'hFFF0;
   localparam logic [15:0]      ADDR_SW  = 16'hFFF1;
   localparam logic [15:0]      ADDR_EVT = 16'hFFF2;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYC - 1);

   logic [31:0]       ram_q [2**RAM_AW];
   logic [31:0]       rdata_q, rdata_d;
   logic [3:0]        led_q, led_d;
   logic [3:0]        sync1_q, sync2_q;
   logic [3:0]        deb_q, deb_d;
   logic [3:0]        evt_q, evt_d;
   logic [3:0]        rise, clr;
   logic [CNT_W-1:0]  cnt_q [4];
   logic [CNT_W-1:0]  cnt_d [4];
   logic              in_ram;
   logic [RAM_AW-1:0] ram_idx;

   // Only the bottom of the address space maps to RAM; no aliasing above it.
   assign in_ram  = (address[15:RAM_AW] == '0);
   assign ram_idx = address[RAM_AW-1:0];

   always_comb begin
      rdata_d = '0;
      if (in_ram) begin
         rdata_d = ram_q[ram_idx];
      end else begin
         case (address)
            ADDR_LED: rdata_d = {28'd0, led_q};
            ADDR_SW:  rdata_d = {28'd0, deb_q};
            ADDR_EVT: rdata_d = {28'd0, evt_q};
            default:  rdata_d = '0;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         deb_d[i] = deb_q[i];
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               deb_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // A rise on the same edge as a W1C keeps the flag set.
   assign rise  = deb_d & ~deb_q;
   assign clr   = (we && address == ADDR_EVT) ? data_fromCPU[3:0] : 4'd0;
   assign evt_d = (evt_q & ~clr) | rise;
   assign led_d = (we && address == ADDR_LED) ? data_fromCPU[3:0] : led_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         rdata_q <= '0;
         led_q   <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         evt_q   <= '0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         rdata_q <= rdata_d;
         led_q   <= led_d;
         sync1_q <= switches;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         evt_q   <= evt_d;
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // RAM contents survive reset, but writes are blocked while it is asserted.
   always_ff @(posedge clock) begin
      if (!reset && we && in_ram) begin
         ram_q[ram_idx] <= data_fromCPU;
      end
   end

   assign data_toCPU = rdata_q;
   assign LEDs       = led_q;

endmodule

// File: tb/tb_scic_mem_bus.sv
// Directed bench for scic_mem_bus: a bus-level model is compared every cycle,
// and literal expectations pin the model at the interesting points.
module tb_scic_mem_bus;

   localparam int RAM_AW = 10;
   localparam int DEB    = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] address;
   logic [31:0] data_fromCPU;
   logic        we;
   logic [3:0]  switches;
   logic [31:0] data_toCPU;
   logic [3:0]  LEDs;

   int n_cmp = 0;
   int n_bad = 0;

   scic_mem_bus #(.RAM_AW(RAM_AW), .DEBOUNCE_CYC(DEB), .CNT_W(5)) dut (
      .clock        (clock),
      .reset        (reset),
      .address      (address),
      .data_fromCPU (data_fromCPU),
      .we           (we),
      .switches     (switches),
      .data_toCPU   (data_toCPU),
      .LEDs         (LEDs)
   );

   always #5 clock = ~clock;

   // Bus model: a switch bit is accepted once its synchronised value has
   // disagreed with the accepted value for DEB consecutive edges.
   logic [31:0] mem [int];
   logic [31:0] m_rd;
   logic        m_rd_known;
   logic [3:0]  m_led, m_s1, m_s2, m_deb, m_evt;
   int          hist [4][$];
   bit          m_valid = 0;

   always @(posedge clock) begin : model
      logic [3:0] m_rise, m_clr, m_ndeb;
      bit         all_diff;
      if (reset) begin
         m_rd = '0; m_rd_known = 1'b1;
         m_led = '0; m_s1 = '0; m_s2 = '0; m_deb = '0; m_evt = '0;
         for (int i = 0; i < 4; i++) hist[i].delete();
         m_valid = 1;
      end else begin
         m_rd_known = 1'b1;
         if (int'(address) < (1 << RAM_AW)) begin
            if (mem.exists(int'(address))) m_rd = mem[int'(address)];
            else begin m_rd = '0; m_rd_known = 1'b0; end
         end else if (address == 16'hFFF0) m_rd = {28'd0, m_led};
         else if (address == 16'hFFF1) m_rd = {28'd0, m_deb};
         else if (address == 16'hFFF2) m_rd = {28'd0, m_evt};
         else m_rd = '0;
         m_clr = '0;
         if (we) begin
            if (int'(address) < (1 << RAM_AW)) mem[int'(address)] = data_fromCPU;
            else if (address == 16'hFFF0) m_led = data_fromCPU[3:0];
            else if (address == 16'hFFF2) m_clr = data_fromCPU[3:0];
         end
         m_ndeb = m_deb;
         for (int i = 0; i < 4; i++) begin
            hist[i].push_back(int'(m_s2[i]));
            if (hist[i].size() > DEB) void'(hist[i].pop_front());
            all_diff = (hist[i].size() == DEB);
            for (int k = 0; k < hist[i].size(); k++)
               if (hist[i][k] != (m_deb[i] ? 0 : 1)) all_diff = 0;
            if (all_diff) m_ndeb[i] = ~m_deb[i];
         end
         m_rise = m_ndeb & ~m_deb;
         m_evt  = (m_evt & ~m_clr) | m_rise;
         m_deb  = m_ndeb;
         m_s2   = m_s1;
         m_s1   = switches;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (m_valid) begin
         check("model_leds", {28'd0, LEDs}, {28'd0, m_led});
         if (m_rd_known) check("model_rdata", data_toCPU, m_rd);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      address = a; data_fromCPU = d; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a);
      address = a; we = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1; address = '0; data_fromCPU = '0; we = 1'b0; switches = '0;
      tick_n(3);
      check("reset_rdata", data_toCPU, 32'h0);
      check("reset_leds", {28'd0, LEDs}, 32'h0);
      reset = 1'b0;

      wr(16'h0005, 32'hDEADBEEF);
      rd(16'h0005);
      check("ram5", data_toCPU, 32'hDEADBEEF);
      address = 16'h0005; data_fromCPU = 32'h12345678; we = 1'b1;
      tick();
      we = 1'b0;
      check("read_before_write", data_toCPU, 32'hDEADBEEF);
      rd(16'h0005);
      check("ram5_new", data_toCPU, 32'h12345678);

      wr(16'hFFF0, 32'hFFFFFFFA);
      check("led_out", {28'd0, LEDs}, 32'hA);
      rd(16'hFFF0);
      check("led_read", data_toCPU, 32'h0000000A);

      address = 16'hFFF1;
      for (int p = 0; p < 3; p++) begin
         switches = 4'h4; tick_n(5);
         switches = 4'h0; tick_n(5);
      end
      check("sw_glitch", data_toCPU, 32'h0);
      rd(16'hFFF2);
      check("evt_glitch", data_toCPU, 32'h0);
      address = 16'hFFF1; switches = 4'h4;
      tick_n(18);
      check("sw_before_accept", data_toCPU, 32'h0);
      tick();
      check("sw_accept", data_toCPU, 32'h4);
      rd(16'hFFF2);
      check("evt_bit2", data_toCPU, 32'h4);

      address = 16'hFFF2; switches = 4'h5;
      tick_n(17);
      data_fromCPU = 32'h4; we = 1'b1;
      tick();
      we = 1'b0;
      tick();
      check("evt_clear2_set0", data_toCPU, 32'h1);
      rd(16'hFFF1);
      check("sw_5", data_toCPU, 32'h5);

      switches = 4'h4; address = 16'hFFF1;
      tick_n(20);
      check("sw_fall", data_toCPU, 32'h4);
      rd(16'hFFF2);
      check("evt_fall_no_set", data_toCPU, 32'h1);
      switches = 4'h5;
      tick_n(17);
      data_fromCPU = 32'h1; we = 1'b1;
      tick();
      we = 1'b0;
      tick();
      check("evt_set_wins", data_toCPU, 32'h1);
      wr(16'hFFF2, 32'h1);
      rd(16'hFFF2);
      check("evt_w1c", data_toCPU, 32'h0);

      wr(16'h0000, 32'h55);
      wr(16'h8000, 32'h99);
      rd(16'h8000);
      check("unmapped_8000", data_toCPU, 32'h0);
      rd(16'h0000);
      check("no_alias_ram0", data_toCPU, 32'h55);
      rd(16'h0400);
      check("above_ram", data_toCPU, 32'h0);
      wr(16'hFFF3, 32'h1234);
      rd(16'hFFF3);
      check("unmapped_fff3", data_toCPU, 32'h0);
      wr(16'hFFF1, 32'hF);
      rd(16'hFFF1);
      check("sw_readonly", data_toCPU, 32'h5);

      wr(16'h0003, 32'h11);
      wr(16'hFFF0, 32'hF);
      check("led_f", {28'd0, LEDs}, 32'hF);
      switches = 4'h7; address = 16'hFFF1;
      tick_n(8);
      reset = 1'b1; address = 16'h0003; data_fromCPU = 32'hBAD; we = 1'b1;
      tick();
      check("rst_rdata", data_toCPU, 32'h0);
      check("rst_leds", {28'd0, LEDs}, 32'h0);
      reset = 1'b0; we = 1'b0;
      rd(16'hFFF0);
      check("rst_led_read", data_toCPU, 32'h0);
      rd(16'hFFF1);
      check("rst_sw", data_toCPU, 32'h0);
      rd(16'hFFF2);
      check("rst_evt", data_toCPU, 32'h0);
      rd(16'h0003);
      check("ram3_kept", data_toCPU, 32'h11);
      address = 16'hFFF1;
      tick_n(16);
      check("sw_after_reset", data_toCPU, 32'h7);
      rd(16'hFFF2);
      check("evt_after_reset", data_toCPU, 32'h7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
